// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4
// ------------------------------------------------------------------------
// Four-channel round-robin arbiter with a registered one-hot grant.
// A rotating priority pointer selects the first requesting channel at or
// after the pointer. A grant is held until the owner releases it (done, or
// its request drops) or until it has been asserted for TIMEOUT cycles.
// Every release is followed by at least one idle cycle with grant == 0000.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    asynchronous active-low reset
//   i_req      per-channel level request, bit i = channel i
//   i_done     release strobe from the current owner, only looked at in GRANT
//   o_grant    registered grant, always 0000 or one-hot
//   o_valid    high exactly when o_grant != 0000
//   o_timeout  one-cycle pulse in the first idle cycle after a forced release
// ------------------------------------------------------------------------
module rr_arbiter_4 #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    input  logic       i_done,
    output logic [3:0] o_grant,
    output logic       o_valid,
    output logic       o_timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_ptr;
    logic [1:0]         r_owner;
    logic [CNT_W-1:0]   r_count;
    logic [3:0]         r_grant;
    logic               r_valid;
    logic               r_timeout;

    logic               w_found;
    logic [1:0]         w_pick;
    logic               w_release;
    logic               w_expired;

    // Priority search: walk ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap) and take
    // the first requesting channel.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && i_req[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_pick  = r_ptr + 2'(k);
            end
        end
    end

    // An owner release wins over an expiring hold, so a simultaneous done
    // and last-allowed cycle never raises timeout.
    assign w_release = i_done || !i_req[r_owner];
    assign w_expired = (r_count == CNT_W'(TIMEOUT - 1));

    // Single FSM with every output registered. The count holds the number of
    // grant cycles already completed minus one, so reaching TIMEOUT-1 at an
    // edge means the grant has been up for TIMEOUT cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_owner   <= 2'd0;
            r_count   <= '0;
            r_grant   <= 4'b0000;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    r_count   <= '0;
                    if (w_found) begin
                        r_grant <= 4'b0001 << w_pick;
                        r_valid <= 1'b1;
                        r_owner <= w_pick;
                        r_state <= GRANT;
                    end else begin
                        r_grant <= 4'b0000;
                        r_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (w_release || w_expired) begin
                        r_grant   <= 4'b0000;
                        r_valid   <= 1'b0;
                        r_timeout <= !w_release;
                        r_ptr     <= r_owner + 2'd1;
                        r_count   <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_count   <= r_count + CNT_W'(1);
                        r_timeout <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_grant   <= 4'b0000;
                    r_valid   <= 1'b0;
                    r_timeout <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_valid   = r_valid;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4
// ------------------------------------------------------------------------
// Directed and randomized stimulus for rr_arbiter_4, compared every cycle
// against a behavioural model that tracks the owner, the priority pointer
// and how many cycles the current grant has been up.
// ------------------------------------------------------------------------
module tb_rr_arbiter_4;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    logic       clk = 1'b0;
    logic       rstN;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: owner index (-1 when idle), pointer,
    // number of cycles the current grant has been asserted, timeout pulse.
    int mOwner;
    int mPtr;
    int mHeld;
    bit mTimeout;

    rr_arbiter_4 #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .i_req     (req),
        .i_done    (done),
        .o_grant   (grant),
        .o_valid   (valid),
        .o_timeout (timeout)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic modelReset();
        mOwner   = -1;
        mPtr     = 0;
        mHeld    = 0;
        mTimeout = 1'b0;
    endtask

    // One clock edge of the arbitration rules applied to the sampled inputs.
    task automatic modelStep(input logic [3:0] r, input logic d);
        if (mOwner < 0) begin
            mTimeout = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (mOwner < 0 && r[(mPtr + k) % 4]) begin
                    mOwner = (mPtr + k) % 4;
                    mHeld  = 1;
                end
            end
        end else if (d || !r[mOwner]) begin
            mPtr     = (mOwner + 1) % 4;
            mOwner   = -1;
            mTimeout = 1'b0;
        end else if (mHeld == TIMEOUT) begin
            mPtr     = (mOwner + 1) % 4;
            mOwner   = -1;
            mTimeout = 1'b1;
        end else begin
            mHeld++;
        end
    endtask

    function automatic logic [3:0] expGrant();
        return (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
    endfunction

    // Drive inputs, let one rising edge pass, update the model, and settle.
    task automatic applyStimulus(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        modelStep(r, d);
        #1;
    endtask

    // Compare all outputs against the model.
    task automatic checkOutput(input string tag);
        logic [3:0] eg;
        eg = expGrant();
        checks++;
        assert (grant === eg) else begin
            errors++;
            $error("FAIL %s grant observed=%b expected=%b", tag, grant, eg);
        end
        checks++;
        assert (valid === (mOwner >= 0)) else begin
            errors++;
            $error("FAIL %s valid observed=%b expected=%b", tag, valid, (mOwner >= 0));
        end
        checks++;
        assert (timeout === mTimeout) else begin
            errors++;
            $error("FAIL %s timeout observed=%b expected=%b", tag, timeout, mTimeout);
        end
    endtask

    // Compare an observed value against a hand-derived constant.
    task automatic checkValue(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Structural invariants, sampled mid-cycle whenever out of reset.
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            checks++;
            assert ($onehot0(grant) && (valid === (|grant))) else begin
                errors++;
                $error("FAIL invariant grant=%b valid=%b", grant, valid);
            end
        end
    end

    initial begin
        logic [3:0] rotTable [13];
        logic [3:0] r;
        logic       d;

        rotTable = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                     4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                     4'b0001};

        // Reset state
        req  = 4'b0000;
        done = 1'b0;
        rstN = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset");
        rstN = 1'b1;

        // Asynchronous reset in the middle of a grant
        applyStimulus(4'b0100, 1'b0);
        checkValue("preResetGrant", grant, 4'b0100);
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        checkValue("asyncGrant", grant, 4'b0000);
        checkValue("asyncValid", {3'b000, valid}, 4'b0000);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(4'b1111, 1'b0);
        checkValue("postResetPtr0", grant, 4'b0001);
        checkOutput("postReset");
        applyStimulus(4'b0000, 1'b0);
        checkOutput("postResetDrop");

        // Single owner released by done in its third cycle, then re-granted
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0100, (i == 3));
            checkOutput($sformatf("single%0d", i));
        end
        checkValue("singleRegrant", grant, 4'b0100);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("singleDrop");

        // Full-contention rotation from a fresh pointer
        rstN = 1'b0;
        #1;
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(4'b1111, (i % 3 == 2));
            checkValue($sformatf("rot%0d", i), grant, rotTable[i]);
            checkOutput($sformatf("rotModel%0d", i));
        end
        applyStimulus(4'b0000, 1'b0);
        checkOutput("rotDrop");

        // Forced release after TIMEOUT cycles, then one-cycle timeout pulse
        for (int i = 0; i < TIMEOUT + 2; i++) begin
            applyStimulus(4'b0010, 1'b0);
            if (i < TIMEOUT || i == TIMEOUT + 1) begin
                checkValue($sformatf("holdGrant%0d", i), grant, 4'b0010);
                checkValue($sformatf("holdTo%0d", i), {3'b000, timeout}, 4'b0000);
            end else begin
                checkValue("expireGrant", grant, 4'b0000);
                checkValue("expirePulse", {3'b000, timeout}, 4'b0001);
            end
            checkOutput($sformatf("hold%0d", i));
        end
        // Same again, but done arrives on the last allowed cycle
        for (int i = 1; i <= TIMEOUT; i++) begin
            applyStimulus(4'b0010, (i == TIMEOUT));
            checkOutput($sformatf("doneLast%0d", i));
        end
        checkValue("doneLastGrant", grant, 4'b0000);
        checkValue("doneLastTo", {3'b000, timeout}, 4'b0000);

        // Pointer skip and wrap
        applyStimulus(4'b1000, 1'b0);
        checkValue("ch3Grant", grant, 4'b1000);
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b1001, 1'b0);
        checkValue("wrapTo0", grant, 4'b0001);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("wrapRelease");
        applyStimulus(4'b0001, 1'b0);
        checkValue("searchWrap", grant, 4'b0001);
        checkOutput("searchWrapModel");

        // Late requester has no effect until the owner releases
        applyStimulus(4'b0101, 1'b0);
        checkValue("lateHold1", grant, 4'b0001);
        applyStimulus(4'b0101, 1'b0);
        checkValue("lateHold2", grant, 4'b0001);
        applyStimulus(4'b0100, 1'b0);
        checkValue("lateGap", grant, 4'b0000);
        applyStimulus(4'b0100, 1'b0);
        checkValue("lateGrant", grant, 4'b0100);
        checkOutput("lateModel");

        // Randomized traffic with sticky requests so holds and timeouts occur
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 5) == 0);
            applyStimulus(r, d);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
